// File: rtl/cam_line_buffer.sv
// Ping-pong camera line buffer: lines are captured into two banks and each
// completed line is replayed over a valid/ready stream while the next is written.
module cam_line_buffer #(
  parameter int LINE_WIDTH = 960,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16
) (
  input  logic              CAM_CLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic              LINE_END,
  input  logic              PIX_VALID,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_SOF,
  output logic              OUT_LAST,
  output logic [ADDR_W-1:0] OUT_LINE,
  output logic              OVERFLOW,
  output logic [7:0]        DROP_CNT
);
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM} state_t;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_WIDTH - 1);

  logic vsync_q, vsync_prev_q, hsync_q, hsync_prev_q, le_q, le_prev_q;
  logic vs_ev, hs_ev, le_ev;

  logic                   wr_bank_q, wr_bank_d, armed_q, armed_d, sof_pend_q, sof_pend_d;
  logic [ADDR_W-1:0]      wr_line_q, wr_line_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             drop_q, drop_d;
  logic [1:0]             full_q, full_d, full_clr;
  logic [1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [1:0]             sof_tag_q, sof_tag_d;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, raddr;
  logic              rd_bank_q, rd_bank_d, rd_done;
  logic              valid_q, valid_d, sof_q, sof_d, last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] line_q, line_d;

  logic [DATA_W-1:0] mem_q [2**(ADDR_W+1)];
  logic [DATA_W-1:0] ram_q;
  logic              wr_en;

  // Strobes are registered, then compared with their history: events act one cycle late.
  always_ff @(posedge CAM_CLK) begin
    if (RESET) begin
      vsync_q <= 1'b0; vsync_prev_q <= 1'b0;
      hsync_q <= 1'b0; hsync_prev_q <= 1'b0;
      le_q    <= 1'b0; le_prev_q    <= 1'b0;
    end else begin
      vsync_q <= VSYNC;    vsync_prev_q <= vsync_q;
      hsync_q <= HSYNC;    hsync_prev_q <= hsync_q;
      le_q    <= LINE_END; le_prev_q    <= le_q;
    end
  end

  assign vs_ev = vsync_q & ~vsync_prev_q;
  assign hs_ev = hsync_q & ~hsync_prev_q;
  assign le_ev = le_q & ~le_prev_q;

  assign wr_en = armed_q & PIX_VALID & (int'(ADDR_IN) < LINE_WIDTH);

  always_ff @(posedge CAM_CLK) begin
    if (wr_en) mem_q[{wr_bank_q, ADDR_IN}] <= DATA_IN;
    ram_q <= mem_q[{rd_bank_q, raddr}];
  end

  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    full_clr   = full_d;
    armed_d    = armed_q;
    wr_bank_d  = wr_bank_q;
    wr_line_d  = wr_line_q;
    sof_pend_d = sof_pend_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    tag_d      = tag_q;
    sof_tag_d  = sof_tag_q;
    if (vs_ev) begin
      wr_line_d  = '0;
      sof_pend_d = 1'b1;
      armed_d    = 1'b0;
      ovf_d      = 1'b0;
      drop_d     = 8'd0;
    end else if (le_ev && armed_q) begin
      full_d[wr_bank_q]    = 1'b1;
      tag_d[wr_bank_q]     = wr_line_q;
      sof_tag_d[wr_bank_q] = sof_pend_q;
      sof_pend_d = 1'b0;
      wr_line_d  = wr_line_q + ADDR_W'(1);
      wr_bank_d  = ~wr_bank_q;
      armed_d    = 1'b0;
    end
    // A bank freed by the reader this very cycle is already available to arm.
    if (hs_ev) begin
      if (!full_clr[wr_bank_d]) begin
        armed_d = 1'b1;
      end else begin
        ovf_d     = 1'b1;
        wr_line_d = wr_line_d + ADDR_W'(1);
        if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
      end
    end
  end

  always_ff @(posedge CAM_CLK) begin
    if (RESET) begin
      wr_bank_q  <= 1'b0;
      armed_q    <= 1'b0;
      sof_pend_q <= 1'b0;
      wr_line_q  <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
      full_q     <= 2'b00;
      tag_q      <= '0;
      sof_tag_q  <= 2'b00;
    end else begin
      wr_bank_q  <= wr_bank_d;
      armed_q    <= armed_d;
      sof_pend_q <= sof_pend_d;
      wr_line_q  <= wr_line_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      full_q     <= full_d;
      tag_q      <= tag_d;
      sof_tag_q  <= sof_tag_d;
    end
  end

  // ram_q always holds the word after the one on the output, so accepts need no bubble.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    raddr     = idx_q + ADDR_W'(1);
    rd_bank_d = rd_bank_q;
    rd_done   = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    sof_d     = sof_q;
    last_d    = last_q;
    line_d    = line_q;
    case (state_q)
      S_IDLE: begin
        raddr = '0;
        if (full_q[rd_bank_q]) state_d = S_PREFETCH;
      end
      S_PREFETCH: begin
        raddr   = ADDR_W'(1);
        valid_d = 1'b1;
        data_d  = ram_q;
        idx_d   = '0;
        sof_d   = sof_tag_q[rd_bank_q];
        last_d  = (LAST_IDX == '0);
        line_d  = tag_q[rd_bank_q];
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (OUT_READY) begin
          if (last_q) begin
            rd_done   = 1'b1;
            valid_d   = 1'b0;
            sof_d     = 1'b0;
            last_d    = 1'b0;
            rd_bank_d = ~rd_bank_q;
            state_d   = S_IDLE;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            data_d = ram_q;
            sof_d  = 1'b0;
            last_d = (idx_d == LAST_IDX);
            raddr  = idx_q + ADDR_W'(2);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CAM_CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sof_q     <= 1'b0;
      last_q    <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sof_q     <= sof_d;
      last_q    <= last_d;
      line_q    <= line_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_SOF   = sof_q;
  assign OUT_LAST  = last_q;
  assign OUT_LINE  = line_q;
  assign OVERFLOW  = ovf_q;
  assign DROP_CNT  = drop_q;
endmodule

// File: tb/tb_cam_line_buffer.sv
// Directed bench for cam_line_buffer: a line-level queue model predicts every
// streamed beat; a few literal checks pin latency, overflow and reset values.
module tb_cam_line_buffer;
  localparam int LW = 960;

  logic        CAM_CLK = 1'b0;
  logic        RESET = 1'b1, VSYNC = 1'b0, HSYNC = 1'b0, LINE_END = 1'b0;
  logic        PIX_VALID = 1'b0, OUT_READY = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic [9:0]  ADDR_IN = '0;
  logic        OUT_VALID, OUT_SOF, OUT_LAST, OVERFLOW;
  logic [15:0] OUT_DATA;
  logic [9:0]  OUT_LINE;
  logic [7:0]  DROP_CNT;

  cam_line_buffer dut (
    .CAM_CLK(CAM_CLK), .RESET(RESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .LINE_END(LINE_END), .PIX_VALID(PIX_VALID), .DATA_IN(DATA_IN),
    .ADDR_IN(ADDR_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_SOF(OUT_SOF), .OUT_LAST(OUT_LAST),
    .OUT_LINE(OUT_LINE), .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
  );

  initial forever #5 CAM_CLK = ~CAM_CLK;

  typedef struct {
    int base;
    int tag;
    bit sof;
  } line_t;

  line_t exp_q[$];
  int    errors = 0, checks = 0;
  int    beat_idx = 0;
  int    m_line = 0;
  bit    m_sof = 1'b0, m_armed = 1'b0;
  bit    rdy_mode = 1'b0;
  logic  rdy_const = 1'b1;
  int    pat_cnt = 0;
  logic  stall_prev = 1'b0;
  logic [28:0] prev_out = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CAM_CLK);
    #1;
  endtask

  // READY: constant level, or the repeating 1,0,0,1 backpressure pattern
  initial forever begin
    @(posedge CAM_CLK);
    #1;
    if (rdy_mode) begin
      OUT_READY = (pat_cnt == 0) || (pat_cnt == 3);
      pat_cnt = (pat_cnt + 1) % 4;
    end else begin
      OUT_READY = rdy_const;
    end
  end

  // Stream checker: every valid beat is compared with the head of the line queue.
  always @(negedge CAM_CLK) begin
    if (RESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {OUT_VALID, OUT_DATA, OUT_SOF, OUT_LAST, OUT_LINE}, prev_out);
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", exp_q.size(), 1);
        end else begin
          chk("data", OUT_DATA, (exp_q[0].base + beat_idx) & 16'hFFFF);
          chk("sof", OUT_SOF, (beat_idx == 0) && exp_q[0].sof);
          chk("last", OUT_LAST, beat_idx == LW - 1);
          chk("line", OUT_LINE, exp_q[0].tag);
          if (OUT_READY) begin
            beat_idx++;
            if (beat_idx == LW) begin
              void'(exp_q.pop_front());
              beat_idx = 0;
            end
          end
        end
      end
      stall_prev = OUT_VALID & ~OUT_READY;
      prev_out   = {OUT_VALID, OUT_DATA, OUT_SOF, OUT_LAST, OUT_LINE};
    end
  end

  task automatic do_vsync();
    VSYNC = 1'b1; tick(); VSYNC = 1'b0;
    m_line = 0; m_sof = 1'b1; m_armed = 1'b0;
    tick(); tick();
  endtask

  // A line start is accepted only while fewer than two lines are held.
  task automatic do_hsync();
    HSYNC = 1'b1; tick(); HSYNC = 1'b0;
    if (exp_q.size() < 2) m_armed = 1'b1;
    else m_line = (m_line + 1) % 1024;
    tick(); tick();
  endtask

  task automatic send_pixels(input int base, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      PIX_VALID = 1'b1; ADDR_IN = 10'(i); DATA_IN = 16'(base + i);
      tick();
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic send_pixel_at(input int addr, input int data);
    PIX_VALID = 1'b1; ADDR_IN = 10'(addr); DATA_IN = 16'(data);
    tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic do_line_end(input int base);
    line_t l;
    LINE_END = 1'b1; tick(); LINE_END = 1'b0;
    if (m_armed) begin
      l.base = base; l.tag = m_line; l.sof = m_sof;
      exp_q.push_back(l);
      m_sof = 1'b0; m_line = (m_line + 1) % 1024; m_armed = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && n < 6000) begin
      tick(); n++;
    end
    chk({name, "_drain_timeout"}, n < 6000, 1);
    repeat (3) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, OUT_VALID, 0);
    chk({tag, "_data"}, OUT_DATA, 0);
    chk({tag, "_sof"}, OUT_SOF, 0);
    chk({tag, "_last"}, OUT_LAST, 0);
    chk({tag, "_line"}, OUT_LINE, 0);
    chk({tag, "_overflow"}, OVERFLOW, 0);
    chk({tag, "_drop_cnt"}, DROP_CNT, 0);
  endtask

  initial begin
    int n;
    RESET = 1'b1; rdy_mode = 1'b0; rdy_const = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("rst");
    RESET = 1'b0;
    tick();

    // single line, READY held high
    do_vsync();
    do_hsync();
    send_pixels(0, 0, LW);
    do_line_end(0);
    tick(); chk("lat_n2_valid", OUT_VALID, 0);
    tick(); chk("lat_n3_valid", OUT_VALID, 0);
    tick(); chk("lat_n4_valid", OUT_VALID, 1);
    chk("first_data", OUT_DATA, 16'h0000);
    chk("first_sof", OUT_SOF, 1);
    chk("first_line", OUT_LINE, 0);
    n = 1;
    while (OUT_VALID && n < 2000) begin
      tick();
      if (OUT_VALID) n++;
    end
    chk("line_cycles", n, LW);
    repeat (3) tick();

    // backpressure 1,0,0,1
    pat_cnt = 0; rdy_mode = 1'b1;
    do_hsync();
    send_pixels(0, 0, LW);
    do_line_end(0);
    wait_drain("bp");
    rdy_mode = 1'b0; rdy_const = 1'b1;
    repeat (2) tick();

    // ping-pong with third line dropped while READY is low
    rdy_const = 1'b0;
    do_vsync();
    for (int k = 0; k < 3; k++) begin
      do_hsync();
      send_pixels(16'h100 * k, 0, LW);
      do_line_end(16'h100 * k);
    end
    repeat (4) tick();
    chk("pp_overflow", OVERFLOW, 1);
    chk("pp_drop_cnt", DROP_CNT, 1);
    chk("pp_stall_valid", OUT_VALID, 1);
    chk("pp_stall_line", OUT_LINE, 0);
    rdy_const = 1'b1;
    wait_drain("pp");

    // VSYNC in the middle of a line
    do_hsync();
    send_pixels(16'h300, 0, 300);
    do_vsync();
    chk("mv_overflow", OVERFLOW, 0);
    chk("mv_drop_cnt", DROP_CNT, 0);
    do_hsync();
    send_pixels(16'h500, 0, LW);
    do_line_end(16'h500);
    wait_drain("mv");

    // out-of-range address ignored
    do_hsync();
    send_pixels(16'h700, 0, 500);
    send_pixel_at(1000, 16'hDEAD);
    send_pixels(16'h700, 500, LW - 500);
    send_pixel_at(1000, 16'hDEAD);
    do_line_end(16'h700);
    wait_drain("rng");

    // reset in the middle of a stream
    do_hsync();
    send_pixels(16'h900, 0, LW);
    do_line_end(16'h900);
    n = 0;
    while (beat_idx != 400 && n < 3000) begin
      tick(); n++;
    end
    chk("rs_wait_timeout", n < 3000, 1);
    RESET = 1'b1;
    exp_q.delete(); beat_idx = 0;
    m_line = 0; m_sof = 1'b0; m_armed = 1'b0;
    tick();
    chk_reset_outputs("rs");
    RESET = 1'b0;
    tick();
    do_vsync();
    do_hsync();
    send_pixels(16'hA00, 0, LW);
    do_line_end(16'hA00);
    wait_drain("rs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_line_buffer.md
# cam_line_buffer

Ping-pong line buffer directly downstream of `mipi_interface`. It captures the 16-bit pixels produced for each camera line into one of two 1024×16 banks. A completed line is replayed to the next stage (display/frame-buffer writer) over a valid/ready stream, while the following line is written into the other bank. Lines that arrive when both banks are still occupied are dropped and counted.

## Interface
Parameters:
- `LINE_WIDTH`, 960: pixels per line; read-out length.
- `ADDR_W`, 10: bank address width.
- `DATA_W`, 16: pixel width.

Ports:
- `CAM_CLK` in 1: single clock; all logic rises on it.
- `RESET` in 1: synchronous, active-high reset.
- `VSYNC` in 1: frame-start strobe from `mipi_interface`; rising edge is significant.
- `HSYNC` in 1: line-start strobe; rising edge is significant.
- `LINE_END` in 1: line-complete strobe; rising edge is significant.
- `PIX_VALID` in 1: pixel strobe (`PCLK` of `mipi_interface`, synchronous to `CAM_CLK`), high 1 cycle per pixel.
- `DATA_IN` in DATA_W: pixel value (`DATA_OUT`).
- `ADDR_IN` in ADDR_W: pixel index within the line (`ADDRA`).
- `OUT_VALID` out 1: `OUT_DATA` is valid.
- `OUT_READY` in 1: consumer accepts the beat.
- `OUT_DATA` out DATA_W: pixel.
- `OUT_SOF` out 1: first pixel of the first line after VSYNC.
- `OUT_LAST` out 1: pixel index LINE_WIDTH-1.
- `OUT_LINE` out ADDR_W: line number within the frame of the line being streamed.
- `OVERFLOW` out 1: sticky; set when a line is dropped; cleared only by RESET or VSYNC.
- `DROP_CNT` out 8: dropped lines in the current frame; saturates at 255.

## Operation
- Edge detect: `VSYNC`, `HSYNC` and `LINE_END` are registered once. Events fire on rising edges only. The history registers clear on reset.
- Per bank: `full` flag, line-number tag, sof tag. Pointers `wr_bank` and `rd_bank` each reset to 0.
- VSYNC edge:
  - Write line counter := 0, `sof_pending` := 1.
  - `armed` := 0; a partially written line is discarded and never marked full.
  - `OVERFLOW` := 0, `DROP_CNT` := 0.
  - Banks that are already full are still drained.
- HSYNC edge:
  - If `full[wr_bank]`=0: `armed` := 1.
  - Otherwise: line dropped, `OVERFLOW` := 1, `DROP_CNT`++ (saturating), write line counter++.
- Write: when `armed` & `PIX_VALID` & `ADDR_IN` < LINE_WIDTH, then `mem[wr_bank][ADDR_IN]` := `DATA_IN`. Out-of-range addresses are ignored.
- LINE_END edge with `armed`=1:
  - `full[wr_bank]` := 1.
  - Tag := write line counter; sof tag := `sof_pending`.
  - Then `sof_pending` := 0, counter++, `wr_bank` toggles, `armed` := 0.
  - A LINE_END edge with `armed`=0 is ignored.
- Read FSM:
  - IDLE: if `full[rd_bank]`, issue RAM read of address 0 and go to PREFETCH.
  - PREFETCH (1 cycle, RAM latency): load the output register and go to STREAM with `OUT_VALID`=1.
  - STREAM: on `OUT_VALID`&`OUT_READY`, advance the index and present the next word on the following cycle with no bubble (address-ahead read).
  - STREAM, last beat: the beat with `OUT_LAST` accepted clears `full[rd_bank]`, toggles `rd_bank` and returns to IDLE.
- Stability: while `OUT_VALID`=1 and `OUT_READY`=0, `OUT_DATA`, `OUT_SOF`, `OUT_LAST` and `OUT_LINE` hold.
- `OUT_SOF` is the sof tag ANDed with index 0.
- Simultaneous events:
  - A full-clear and an HSYNC edge on the same bank in the same cycle: the clear wins, and the line arms.
  - A VSYNC edge and a LINE_END edge in the same cycle: VSYNC wins, and the line is discarded.
- Counter arithmetic: the write line counter wraps modulo 2^ADDR_W.

## Timing
- Reset values: `OUT_VALID`=0, `OUT_DATA`=0, `OUT_SOF`=0, `OUT_LAST`=0, `OUT_LINE`=0, `OVERFLOW`=0, `DROP_CNT`=0. FSM starts in IDLE, both `full` flags are 0, `armed`=0.
- Edge latency: an event is acted on in the cycle after the strobe is sampled high.
- Read-out latency:
  - `LINE_END` sampled high at edge N: `full` set at N+1, PREFETCH at N+2, `OUT_VALID`=1 from N+3.
  - With `OUT_READY` held at 1, a line takes exactly LINE_WIDTH consecutive cycles.
  - IDLE lasts at least 1 cycle between lines.
- RESET mid-operation: `OUT_VALID`=0 after the reset edge. Stored lines are discarded. Banks are not cleared.

## Test plan
- Single line: VSYNC, HSYNC, 960 pixels with DATA=i at ADDR=i, LINE_END, READY=1 -> 960 beats of data 0..959. `OUT_SOF` only on beat 0, `OUT_LAST` only on beat 959, `OUT_LINE`=0, first VALID 3 cycles after LINE_END.
- Backpressure: same line with READY pattern 1,0,0,1 repeating -> data sequence 0..959 exactly once. Outputs are stable during every stall.
- Ping-pong/overflow: READY=0 while lines 0, 1 and 2 (data i+0x100·line) are written -> line 2 dropped, `OVERFLOW`=1, `DROP_CNT`=1. Then READY=1 -> lines 0 and 1 stream in order with `OUT_LINE` 0, 1.
- Mid-line VSYNC: VSYNC after 300 pixels of line 3 -> that line is never streamed. The next full line streams with `OUT_LINE`=0, `OUT_SOF`=1, `OVERFLOW`=0.
- Range check: a pixel at ADDR_IN=1000 with DATA=0xDEAD -> no write. `OUT_DATA` never shows 0xDEAD, and beat 959 is unchanged.
- Reset mid-stream: RESET high at beat 400 -> `OUT_VALID`=0 on the next cycle, all outputs at reset values. A following line streams normally from index 0.
